// File: rtl/multi_adder_pkg.sv
// Shared types and constants for the multi-adder scheduler.
// Holds the FSM state encoding and the default sizing.
package multi_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int DP_LATENCY  = 11;
    localparam int DEF_N_REQ   = 4;
    localparam int DEF_TIMEOUT = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first active request strictly after ptr, with wrap.
// Purely combinational; ptr itself is searched last.
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt,
    output logic         any
);

    logic [W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = '0;
        for (int i = N; i >= 1; i--) begin
            idx = ptr + W'(i);
            if (req[idx]) begin
                gnt = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_adder_sched.sv
// Schedules N_REQ requesters onto one shared multi-adder datapath,
// one operation in flight, with a watchdog and sticky error flags.
module multi_adder_sched
    import multi_adder_pkg::*;
#(
    parameter  int N_REQ   = DEF_N_REQ,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int SW      = $clog2(N_REQ)
) (
    input  logic             prj_clk,
    input  logic             prj_rst_n,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    output logic             dp_tvalid,
    output logic [SW-1:0]    dp_sel,
    input  logic             dp_done,
    output logic [N_REQ-1:0] rsp_valid,
    output logic             rsp_err,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr,
    output logic             spurious_err
);

    localparam int CW = $clog2(TIMEOUT);

    state_t           state, state_n;
    logic [SW-1:0]    ptr, ptr_n;
    logic [SW-1:0]    sel_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [N_REQ-1:0] rdy_n, rv_n;
    logic             tv_n, err_n;
    logic             to_set, sp_set;
    logic [SW-1:0]    gnt;
    logic             any;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .any (any)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = dp_sel;
        cnt_n   = cnt;
        rdy_n   = '0;
        rv_n    = '0;
        tv_n    = 1'b0;
        err_n   = 1'b0;
        to_set  = 1'b0;
        sp_set  = dp_done && (state != S_WAIT);
        unique case (state)
            S_IDLE: begin
                if (any) begin
                    state_n    = S_ISSUE;
                    ptr_n      = gnt;
                    sel_n      = gnt;
                    rdy_n[gnt] = 1'b1;
                    tv_n       = 1'b1;
                    cnt_n      = '0;
                end
            end
            S_ISSUE: begin
                state_n = S_WAIT;
                cnt_n   = cnt + CW'(1);
            end
            S_WAIT: begin
                // A done pulse in the final watchdog cycle still counts as success.
                if (dp_done) begin
                    state_n      = S_RESP;
                    rv_n[dp_sel] = 1'b1;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_n      = S_RESP;
                    rv_n[dp_sel] = 1'b1;
                    err_n        = 1'b1;
                    to_set       = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prj_clk or negedge prj_rst_n) begin
        if (!prj_rst_n) begin
            state        <= S_IDLE;
            ptr          <= SW'(N_REQ - 1);
            dp_sel       <= '0;
            cnt          <= '0;
            req_ready    <= '0;
            rsp_valid    <= '0;
            dp_tvalid    <= 1'b0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            spurious_err <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            dp_sel    <= sel_n;
            cnt       <= cnt_n;
            req_ready <= rdy_n;
            rsp_valid <= rv_n;
            dp_tvalid <= tv_n;
            rsp_err   <= err_n;
            busy      <= (state_n != S_IDLE);
            if (to_set)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;
            if (sp_set)
                spurious_err <= 1'b1;
            else if (err_clr)
                spurious_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_adder_sched.sv
// Directed bench for multi_adder_sched with N_REQ=4, TIMEOUT=32.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_multi_adder_sched;

    logic       prj_clk = 1'b0;
    logic       prj_rst_n;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic       dp_tvalid;
    logic [1:0] dp_sel;
    logic       dp_done;
    logic [3:0] rsp_valid;
    logic       rsp_err;
    logic       busy;
    logic       timeout_err;
    logic       err_clr;
    logic       spurious_err;

    int n_pass  = 0;
    int n_total = 0;

    multi_adder_sched #(.N_REQ(4), .TIMEOUT(32)) dut (
        .prj_clk      (prj_clk),
        .prj_rst_n    (prj_rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .dp_tvalid    (dp_tvalid),
        .dp_sel       (dp_sel),
        .dp_done      (dp_done),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr),
        .spurious_err (spurious_err)
    );

    always #5 prj_clk = ~prj_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge prj_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_rspv"}, rsp_valid, 0);
        chk({tag, "_tvalid"}, dp_tvalid, 0);
        chk({tag, "_rsperr"}, rsp_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_toerr"}, timeout_err, 0);
        chk({tag, "_sperr"}, spurious_err, 0);
        chk({tag, "_sel"}, dp_sel, 0);
    endtask

    task automatic do_reset();
        prj_rst_n = 1'b0;
        repeat (3) tick();
        prj_rst_n = 1'b1;
        tick();
    endtask

    // From IDLE with a request pending: next edge grants.
    task automatic issue(input string tag, input logic [3:0] rdy,
                         input logic [1:0] sel);
        tick();
        chk({tag, "_ready"}, req_ready, rdy);
        chk({tag, "_tvalid"}, dp_tvalid, 1);
        chk({tag, "_sel"}, dp_sel, sel);
        chk({tag, "_busy"}, busy, 1);
    endtask

    // Datapath answers 11 cycles after the start pulse.
    task automatic complete(input string tag, input logic [3:0] rv,
                            input logic [1:0] sel);
        repeat (11) tick();
        chk({tag, "_norsp"}, rsp_valid, 0);
        chk({tag, "_selmid"}, dp_sel, sel);
        dp_done = 1'b1;
        tick();
        dp_done = 1'b0;
        chk({tag, "_rspv"}, rsp_valid, rv);
        chk({tag, "_rsperr"}, rsp_err, 0);
        chk({tag, "_selrsp"}, dp_sel, sel);
        tick();
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_rspoff"}, rsp_valid, 0);
    endtask

    initial begin
        prj_rst_n = 1'b0;
        req_valid = '0;
        dp_done   = 1'b0;
        err_clr   = 1'b0;
        #3;
        chk_all_zero("rst");
        do_reset();
        chk_all_zero("rst_rel");

        // Single request, normal completion.
        req_valid = 4'b0001;
        issue("single", 4'b0001, 2'd0);
        req_valid = '0;
        tick();
        chk("single_rdy_pulse", req_ready, 0);
        chk("single_tv_pulse", dp_tvalid, 0);
        repeat (10) tick();
        dp_done = 1'b1;
        tick();
        dp_done = 1'b0;
        chk("single_rspv", rsp_valid, 4'b0001);
        chk("single_rsperr", rsp_err, 0);
        chk("single_sperr", spurious_err, 0);
        tick();
        chk("single_idle", busy, 0);

        // Round-robin from reset with everyone requesting.
        do_reset();
        req_valid = 4'b1111;
        issue("rr0", 4'b0001, 2'd0);
        complete("rr0", 4'b0001, 2'd0);
        issue("rr1", 4'b0010, 2'd1);
        complete("rr1", 4'b0010, 2'd1);
        issue("rr2", 4'b0100, 2'd2);
        complete("rr2", 4'b0100, 2'd2);
        issue("rr3", 4'b1000, 2'd3);
        complete("rr3", 4'b1000, 2'd3);
        issue("rr4", 4'b0001, 2'd0);
        req_valid = '0;
        complete("rr4", 4'b0001, 2'd0);

        // Watchdog expiry.
        req_valid = 4'b0010;
        issue("to", 4'b0010, 2'd1);
        req_valid = '0;
        repeat (31) tick();
        chk("to_early", rsp_valid, 0);
        chk("to_early_flag", timeout_err, 0);
        tick();
        chk("to_rspv", rsp_valid, 4'b0010);
        chk("to_rsperr", rsp_err, 1);
        chk("to_flag", timeout_err, 1);
        tick();
        chk("to_rsperr_off", rsp_err, 0);
        chk("to_sticky", timeout_err, 1);
        tick();
        chk("to_sticky2", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_clr", timeout_err, 0);

        // Done in the last watchdog cycle wins over timeout.
        req_valid = 4'b0100;
        issue("edge", 4'b0100, 2'd2);
        req_valid = '0;
        repeat (31) tick();
        chk("edge_pre", rsp_valid, 0);
        dp_done = 1'b1;
        tick();
        dp_done = 1'b0;
        chk("edge_rspv", rsp_valid, 4'b0100);
        chk("edge_rsperr", rsp_err, 0);
        chk("edge_toerr", timeout_err, 0);
        chk("edge_sperr", spurious_err, 0);
        tick();

        // Done while idle is spurious; set beats a coincident clear.
        dp_done = 1'b1;
        tick();
        dp_done = 1'b0;
        chk("sp_flag", spurious_err, 1);
        chk("sp_norsp", rsp_valid, 0);
        chk("sp_idle", busy, 0);
        tick();
        chk("sp_stay", busy, 0);
        chk("sp_notv", dp_tvalid, 0);
        dp_done = 1'b1;
        err_clr = 1'b1;
        tick();
        dp_done = 1'b0;
        chk("sp_setwins", spurious_err, 1);
        tick();
        err_clr = 1'b0;
        chk("sp_clr", spurious_err, 0);

        // Reset during WAIT, then a late done and a fresh grant.
        req_valid = 4'b0001;
        issue("rw", 4'b0001, 2'd0);
        req_valid = '0;
        repeat (4) tick();
        chk("rw_busy", busy, 1);
        prj_rst_n = 1'b0;
        #1;
        chk_all_zero("rw_async");
        repeat (2) tick();
        prj_rst_n = 1'b1;
        tick();
        dp_done = 1'b1;
        tick();
        dp_done = 1'b0;
        chk("rw_late_sp", spurious_err, 1);
        chk("rw_late_norsp", rsp_valid, 0);
        chk("rw_late_idle", busy, 0);
        req_valid = 4'b0100;
        issue("rw2", 4'b0100, 2'd2);
        req_valid = '0;
        complete("rw2", 4'b0100, 2'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
